// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg: feeder state encoding, array defaults and drain-length helper.
// Revision: 1.0
// ============================================================================
package systolic_pkg;

  localparam int unsigned DEFAULT_N          = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_e;

  // Cycles for the last operand to ripple from the edge to PE(N-1,N-1).
  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// skew_delay_line: DEPTH-stage zero-on-reset shift register (DEPTH=0 is a wire).
// Revision: 1.0
// ============================================================================
module skew_delay_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_passthru
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_ni, clr_i};
      assign q_o         = d_i;
    end else begin : g_shift
      logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_d;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;

      always_comb begin
        stage_d = stage_q;
        if (clr_i) begin
          stage_d = '0;
        end else begin
          stage_d[0] = d_i;
          for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// systolic_skew_feeder: clears the PE array, streams K skewed operand pairs
// onto its edges, drains, then pulses done. Define SYSTOLIC_FEEDER_ABORT_EN
// to add the abort_i port.
// Revision: 1.0
// ============================================================================
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned K_WIDTH    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [K_WIDTH-1:0]      k_len_i,
  input  logic [N*DATA_WIDTH-1:0] a_vec_i,
  input  logic [N*DATA_WIDTH-1:0] b_vec_i,
  input  logic                    vec_valid_i,
`ifdef SYSTOLIC_FEEDER_ABORT_EN
  input  logic                    abort_i,
`endif
  output logic                    vec_ready_o,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o,
  output logic                    array_rst_no,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned       DCNT_W     = $clog2(2 * N);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(drain_len(N) - 1);

  feeder_state_e           state_q, state_d;
  logic [K_WIDTH-1:0]      k_q, k_d;
  logic [K_WIDTH-1:0]      acc_q, acc_d, acc_inc;
  logic [DCNT_W-1:0]       drain_q, drain_d;
  logic                    array_rst_q, array_rst_d;
  logic [N*DATA_WIDTH-1:0] left_q, left_d, up_q, up_d;
  logic [N*DATA_WIDTH-1:0] push_a, push_b, line_a, line_b;
  logic                    abort_hit;
  logic                    accept;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
  assign abort_hit = abort_i &&
                     (state_q == CLEAR || state_q == STREAM || state_q == DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  assign vec_ready_o = (state_q == STREAM) && (acc_q < k_q);
  assign accept      = vec_valid_i && vec_ready_o && !abort_hit;
  assign acc_inc     = acc_q + K_WIDTH'(1);
  // Non-accept cycles inject zeros so both edges stay aligned.
  assign push_a      = accept ? a_vec_i : '0;
  assign push_b      = accept ? b_vec_i : '0;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          k_d     = k_len_i;
          acc_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        drain_d = '0;
        state_d = (k_q != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (accept) begin
          acc_d = acc_inc;
          if (acc_inc == k_q) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DCNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
    end
    // The array clear tracks CLEAR and is also pulsed once after an abort.
    array_rst_d = (state_d != CLEAR) && !abort_hit;
    left_d      = abort_hit ? '0 : line_a;
    up_d        = abort_hit ? '0 : line_b;
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(
        .DEPTH      (i),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_line_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (abort_hit),
        .d_i    (push_a[i*DATA_WIDTH +: DATA_WIDTH]),
        .q_o    (line_a[i*DATA_WIDTH +: DATA_WIDTH])
      );
      skew_delay_line #(
        .DEPTH      (i),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_line_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (abort_hit),
        .d_i    (push_b[i*DATA_WIDTH +: DATA_WIDTH]),
        .q_o    (line_b[i*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      drain_q     <= '0;
      array_rst_q <= 1'b0;
      left_q      <= '0;
      up_q        <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      drain_q     <= drain_d;
      array_rst_q <= array_rst_d;
      left_q      <= left_d;
      up_q        <= up_d;
    end
  end

  assign left_o       = left_q;
  assign up_o         = up_q;
  assign array_rst_no = array_rst_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// tb_systolic_skew_feeder: directed jobs into an N=4 feeder driving a PE-array
// model; a scoreboard checks results and done_o timing on every done pulse.
// Revision: 1.0
// ============================================================================
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = 16;
  localparam int RW = N * N * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic [N*DW-1:0] a_vec, b_vec;
  logic          valid;
  logic          ready;
  logic [N*DW-1:0] left, up;
  logic          arst_n, busy, done;
`ifdef SYSTOLIC_FEEDER_ABORT_EN
  logic          abort;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .K_WIDTH(KW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .k_len_i      (k_len),
    .a_vec_i      (a_vec),
    .b_vec_i      (b_vec),
    .vec_valid_i  (valid),
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    .abort_i      (abort),
`endif
    .vec_ready_o  (ready),
    .left_o       (left),
    .up_o         (up),
    .array_rst_no (arst_n),
    .busy_o       (busy),
    .done_o       (done)
  );

  // PE array model: a flows right, b flows down, acc += a*b, async clear.
  logic [DW-1:0] pa [N][N];
  logic [DW-1:0] pb [N][N];
  logic [DW-1:0] acc[N][N];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return left[i*DW +: DW];
    return pa[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    if (i == 0) return up[j*DW +: DW];
    return pb[i-1][j];
  endfunction

  always @(posedge clk or negedge arst_n) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!arst_n) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= a_in(i, j);
          pb[i][j]  <= b_in(i, j);
          acc[i][j] <= acc[i][j] + a_in(i, j) * b_in(i, j);
        end
      end
    end
  end

  function automatic logic [RW-1:0] res_flat();
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*DW +: DW] = acc[i][j];
    return r;
  endfunction

  function automatic logic [RW-1:0] mk(input int m[16]);
    logic [RW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*DW +: DW] = m[k];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] vec(input int v0, input int v1, input int v2, input int v3);
    return {v3, v2, v1, v0};
  endfunction

  // Hand-computed result matrices, row-major, N=4.
  int m_basic[16] = '{19, 22, 0, 0, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_skew [16] = '{10, 20, 30, 40, 11, 22, 33, 44, 12, 24, 36, 48, 13, 26, 39, 52};
  int m_job2 [16] = '{2, 4, 0, 0, 10, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int m_zero [16] = '{default: 0};

  typedef struct packed {
    logic [RW-1:0] res;
    logic [31:0]   when;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_job(input logic [RW-1:0] r, input int when);
    sb.push_back('{res: r, when: 32'(when)});
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done_o high at cycle %0d, expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", res_flat(), mon_e.res);
        check("done_cycle", cyc, mon_e.when);
      end
    end
  end

  task automatic start_job(input int k, output int s);
    start = 1'b1;
    k_len = KW'(k);
    s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("clear_arst_low", arst_n, 0);
    check("clear_busy", busy, 1);
    check("clear_ready", ready, 0);
    @(posedge clk); #1;
    check("post_clear_arst", arst_n, 1);
    check("first_ready", ready, (k != 0));
  endtask

  task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, output int e);
    int n = 0;
    a_vec = a;
    b_vec = b;
    valid = 1'b1;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", ready, 1);
    @(posedge clk); #1;
    e     = cyc;
    valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e0, e1, dbasic;
    logic seen;
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    a_vec = '0;
    b_vec = '0;
    valid = 1'b0;
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_arst", arst_n, 0);
    check("rst_left", left, 0);
    check("rst_up", up, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_after_reset", arst_n, 1);

    // Basic 2x2 job in the top-left corner, valid every cycle.
    start_job(2, s);
    send(vec(1, 3, 0, 0), vec(5, 6, 0, 0), e0);
    send(vec(2, 4, 0, 0), vec(7, 8, 0, 0), e1);
    expect_job(mk(m_basic), e1 + 7);
    dbasic = e1 - s;
    wait_idle();

    // Same job with three bubble cycles between the vectors.
    start_job(2, s);
    send(vec(1, 3, 0, 0), vec(5, 6, 0, 0), e0);
    repeat (3) @(posedge clk);
    #1;
    send(vec(2, 4, 0, 0), vec(7, 8, 0, 0), e1);
    expect_job(mk(m_basic), e1 + 7);
    check("bubble_delay", e1 - s, dbasic + 3);
    wait_idle();

    // Skew: lane i shows its element for exactly one cycle at e+i.
    start_job(1, s);
    send(vec(10, 11, 12, 13), vec(1, 2, 3, 4), e0);
    expect_job(mk(m_skew), e0 + 7);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("skew_left_t%0d_l%0d", t, i), left[i*DW +: DW], (i == t) ? 10 + i : 0);
        check($sformatf("skew_up_t%0d_l%0d", t, i), up[i*DW +: DW], (i == t) ? 1 + i : 0);
      end
      @(posedge clk); #1;
    end
    wait_idle();

    // K = 0: one clear cycle, done at s+2, never ready.
    start_job(0, s);
    expect_job(mk(m_zero), s + 2);
    seen = 1'b0;
    repeat (4) begin
      seen = seen | ready;
      @(posedge clk); #1;
    end
    check("k0_ready_never", seen, 0);
    wait_idle();

    // Back-to-back: start while busy is ignored, start after done accepted.
    start_job(2, s);
    send(vec(1, 3, 0, 0), vec(5, 6, 0, 0), e0);
    start = 1'b1;
    k_len = KW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    send(vec(2, 4, 0, 0), vec(7, 8, 0, 0), e1);
    expect_job(mk(m_basic), e1 + 7);
    wait_idle();
    start_job(2, s);
    send(vec(2, 1, 0, 0), vec(1, 2, 0, 0), e0);
    send(vec(0, 3, 0, 0), vec(3, 4, 0, 0), e1);
    expect_job(mk(m_job2), e1 + 7);
    wait_idle();

    // Asynchronous reset in the middle of STREAM.
    start_job(3, s);
    send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), e0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_left", left, 0);
    check("midrst_up", up, 0);
    check("midrst_busy", busy, 0);
    check("midrst_arst", arst_n, 0);
    check("midrst_ready", ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_arst", arst_n, 1);
    check("postrst_busy", busy, 0);
    check("postrst_left", left, 0);
    repeat (20) @(posedge clk);
    #1;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
    // Abort in DRAIN while the upper lanes still carry data.
    start_job(2, s);
    send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), e0);
    send(vec(1, 2, 3, 4), vec(5, 6, 7, 8), e1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_left", left, 0);
    check("abort_up", up, 0);
    check("abort_busy", busy, 0);
    check("abort_arst", arst_n, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    check("postabort_arst", arst_n, 1);
    check("postabort_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
